// File: rtl/nasti_uart_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nasti_uart_pkg
// Description : Shared constants and types for the NASTI-lite UART reader.
//               Holds the UART register map, the line-status data-ready bit,
//               the OKAY response code and the reader FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package nasti_uart_pkg;

  localparam logic [2:0] UART_RBR_ADDR   = 3'd0;
  localparam logic [2:0] UART_LSR_ADDR   = 3'd5;
  localparam int         LSR_DR_BIT      = 0;
  localparam logic [1:0] NASTI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POLL_AR = 3'd1,
    ST_POLL_R  = 3'd2,
    ST_GAP     = 3'd3,
    ST_DATA_AR = 3'd4,
    ST_DATA_R  = 3'd5
  } reader_state_e;

endpackage : nasti_uart_pkg
`default_nettype wire

// File: rtl/nasti_uart_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : nasti_uart_reader_if
// Description : Read-channel subset (ar/r) of the NASTI-lite bus between the
//               UART reader (master) and the UART device emulation (slave).
//   ar_addr  [2:0] read address          ar_valid / ar_ready  address handshake
//   r_data   [7:0] read data             r_resp [1:0]         read response
//   r_valid / r_ready                    read data handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface nasti_uart_reader_if;

  logic [2:0] ar_addr;
  logic       ar_valid;
  logic       ar_ready;
  logic [7:0] r_data;
  logic [1:0] r_resp;
  logic       r_valid;
  logic       r_ready;

  modport master (
    output ar_addr, ar_valid, r_ready,
    input  ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  ar_addr, ar_valid, r_ready,
    output ar_ready, r_data, r_resp, r_valid
  );

endinterface : nasti_uart_reader_if
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous byte FIFO for received UART data. Head entry is
//               read straight from the storage flops.
//   clk, rst         clock, synchronous active-high reset
//   i_push, i_data   write strobe and byte (ignored when full)
//   i_pop            read strobe (ignored when empty)
//   o_data           head byte
//   o_full, o_empty  occupancy flags
// Parameters  : DEPTH - entries, power of two, >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_push,
  input  wire logic [7:0] i_data,
  input  wire logic       i_pop,
  output logic      [7:0] o_data,
  output logic            o_full,
  output logic            o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == C_FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/nasti_uart_reader.sv
`default_nettype none
// ============================================================================
// Module      : nasti_uart_reader
// Description : Read-side NASTI-lite initiator for the UART device emulation.
//               Polls LSR, fetches RBR when data-ready is set, buffers bytes
//               in a FIFO and offers them on a valid/ready byte stream.
//   clk, rst                       clock, synchronous active-high reset
//   i_enable                       polling permitted when high
//   m_bus (master modport)         ar/r channels toward the UART emulation
//   o_rx_data/o_rx_valid/i_rx_ready received byte stream
//   o_err_count                    saturating count of non-OKAY responses
// Parameters  : FIFO_DEPTH (power of two, >= 2), POLL_GAP (1..255)
// Macro       : NASTI_UART_READER_BACKOFF_EN - empty LSR polls wait POLL_GAP
//               cycles in GAP before the next poll; otherwise re-poll at once.
// Revision    : 1.0 - initial release
// ============================================================================
module nasti_uart_reader
  import nasti_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_GAP   = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_enable,
  nasti_uart_reader_if.master m_bus,
  output logic       [7:0] o_rx_data,
  output logic             o_rx_valid,
  input  wire logic        i_rx_ready,
  output logic       [7:0] o_err_count
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if ((POLL_GAP < 1) || (POLL_GAP > 255)) begin : g_bad_poll_gap
    $error("POLL_GAP must be in 1..255");
  end

  reader_state_e r_state;
  reader_state_e w_next;
  logic          r_ar_valid;
  logic [2:0]    r_ar_addr;
  logic          r_r_ready;
  logic [7:0]    r_err_count;
  logic          w_push;
  logic          w_err_inc;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_resp_ok;

  assign w_resp_ok = (m_bus.r_resp == NASTI_RESP_OKAY);

`ifdef NASTI_UART_READER_BACKOFF_EN
  logic [7:0] r_gap_cnt;

  // Preloaded while outside GAP so the count is ready on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap_cnt <= '0;
    end else if (r_state != ST_GAP) begin
      r_gap_cnt <= 8'(POLL_GAP - 1);
    end else if (r_gap_cnt != 8'd0) begin
      r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_err_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable && !w_fifo_full) begin
          w_next = ST_POLL_AR;
        end
      end
      ST_POLL_AR: begin
        if (m_bus.ar_ready) begin
          w_next = ST_POLL_R;
        end
      end
      ST_POLL_R: begin
        if (m_bus.r_valid) begin
          if (!w_resp_ok) begin
            w_err_inc = 1'b1;
            w_next    = ST_IDLE;
          end else if (m_bus.r_data[LSR_DR_BIT]) begin
            w_next = ST_DATA_AR;
          end else begin
`ifdef NASTI_UART_READER_BACKOFF_EN
            w_next = ST_GAP;
`else
            w_next = ST_IDLE;
`endif
          end
        end
      end
`ifdef NASTI_UART_READER_BACKOFF_EN
      ST_GAP: begin
        if (!i_enable || (r_gap_cnt == 8'd0)) begin
          w_next = ST_IDLE;
        end
      end
`endif
      ST_DATA_AR: begin
        if (m_bus.ar_ready) begin
          w_next = ST_DATA_R;
        end
      end
      ST_DATA_R: begin
        if (m_bus.r_valid) begin
          w_push    = w_resp_ok;
          w_err_inc = !w_resp_ok;
          w_next    = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they line up exactly
  // with the state that owns them and stay stable until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar_valid  <= 1'b0;
      r_ar_addr   <= 3'd0;
      r_r_ready   <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_ar_valid <= (w_next == ST_POLL_AR) || (w_next == ST_DATA_AR);
      if (w_next == ST_POLL_AR) begin
        r_ar_addr <= UART_LSR_ADDR;
      end else if (w_next == ST_DATA_AR) begin
        r_ar_addr <= UART_RBR_ADDR;
      end
      r_r_ready <= (w_next == ST_POLL_R) || (w_next == ST_DATA_R);
      if (w_err_inc && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign m_bus.ar_valid = r_ar_valid;
  assign m_bus.ar_addr  = r_ar_addr;
  assign m_bus.r_ready  = r_r_ready;
  assign o_err_count    = r_err_count;
  assign o_rx_valid     = !w_fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (m_bus.r_data),
    .i_pop   (o_rx_valid && i_rx_ready),
    .o_data  (o_rx_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule : nasti_uart_reader
`default_nettype wire
